// File: rtl/dummy_pkg.sv
// Shared types and constants for the dummy coprocessor blocks.
// The result buffer's module parameters default to the widths defined here.
package dummy_pkg;

    localparam int RES_WIDTH = 32;
    localparam int RES_IDW   = 4;

    typedef logic [RES_IDW-1:0] res_id_t;

    typedef struct packed {
        logic                 killed;
        res_id_t              id;
        logic [RES_WIDTH-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/dummy_res_fifo.sv
// In-order result buffer between the dummy coprocessor and the CPU result port,
// with per-ID kill of speculative results and a full flush.
module dummy_res_fifo
    import dummy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = RES_WIDTH,
    parameter int IDW   = RES_IDW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [IDW-1:0]             id_i,
    input  logic                       kill_valid_i,
    input  logic [IDW-1:0]             kill_id_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [IDW-1:0]             id_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Same layout as res_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic             killed;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    entry_t          head;
    logic            empty;
    logic            full;
    logic            head_killed;
    logic            push;
    logic            pop;

    assign head        = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign head_killed = !empty && head.killed;

    assign ready_o = !full;
    assign valid_o = !empty && !head.killed;
    assign data_o  = head.data;
    assign id_o    = head.id;
    assign empty_o = empty;
    assign full_o  = full;
    assign count_o = count_q;

    assign push = valid_i && !full;
    // A killed head is retired without a handshake, one per cycle.
    assign pop  = (valid_o && ready_i) || head_killed;

    always_comb begin
        // NOTE: every signal is given a default first so no path leaves it unassigned and no latch is inferred.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (kill_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].id == kill_id_i) begin
                    mem_d[i].killed = 1'b1;
                end
            end
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{killed: kill_valid_i && (id_i == kill_id_i),
                                    id:     id_i,
                                    data:   data_i};
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: storage is cleared on reset so data_o/id_o come up at zero rather than X.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
